// File: rtl/alu.sv
// Registered 8-bit ALU with a local 4-bit status register (V,N,Z,C).
// One operation per clock; carry-dependent ops read the flags from the previous edge.
module alu (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] reg_out,
  output logic [3:0] SREG,
  input  logic [3:0] function_select_lines,
  input  logic [7:0] A,
  input  logic [7:0] B
);

  typedef enum logic [3:0] {
    OP_MOV = 4'd0,  OP_ADD = 4'd1,  OP_SUB = 4'd2,  OP_AND = 4'd3,
    OP_ADC = 4'd4,  OP_SBC = 4'd5,  OP_OR  = 4'd6,  OP_XOR = 4'd7,
    OP_NOT = 4'd8,  OP_NEG = 4'd9,  OP_LSL = 4'd10, OP_LSR = 4'd11,
    OP_ASR = 4'd12, OP_ROL = 4'd13, OP_ROR = 4'd14, OP_CMP = 4'd15
  } op_e;

  logic [7:0] reg_out_q, reg_out_d;
  logic [3:0] sreg_q, sreg_d;

  op_e        op;
  logic       c_in;
  logic [8:0] sum9, diff9;
  logic [7:0] minuend, subtrahend;
  logic       carry_in_used;
  logic [7:0] res;
  logic       c_new, v_new;

  assign op   = op_e'(function_select_lines);
  assign c_in = sreg_q[0];

  // Shared 9-bit adder/subtractor; bit 8 of the difference is the borrow.
  always_comb begin
    carry_in_used = ((op == OP_ADC) || (op == OP_SBC)) ? c_in : 1'b0;
    minuend       = (op == OP_NEG) ? 8'h00 : A;
    subtrahend    = (op == OP_NEG) ? A : B;
    sum9          = {1'b0, A} + {1'b0, B} + {8'd0, carry_in_used};
    diff9         = {1'b0, minuend} - {1'b0, subtrahend} - {8'd0, carry_in_used};
  end

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    res   = 8'h00;
    c_new = c_in;
    v_new = 1'b0;
    unique case (op)
      OP_MOV: res = B;
      OP_AND: res = A & B;
      OP_OR:  res = A | B;
      OP_XOR: res = A ^ B;
      OP_NOT: res = ~A;
      OP_ADD, OP_ADC: begin
        res   = sum9[7:0];
        c_new = sum9[8];
        v_new = (A[7] == B[7]) && (res[7] != A[7]);
      end
      OP_SUB, OP_SBC, OP_CMP, OP_NEG: begin
        res   = diff9[7:0];
        c_new = diff9[8];
        v_new = (minuend[7] != subtrahend[7]) && (res[7] != minuend[7]);
      end
      OP_LSL: begin
        res   = {A[6:0], 1'b0};
        c_new = A[7];
        v_new = res[7] ^ c_new;
      end
      OP_LSR: begin
        res   = {1'b0, A[7:1]};
        c_new = A[0];
        v_new = res[7] ^ c_new;
      end
      OP_ASR: begin
        res   = {A[7], A[7:1]};
        c_new = A[0];
        v_new = res[7] ^ c_new;
      end
      OP_ROL: begin
        res   = {A[6:0], c_in};
        c_new = A[7];
        v_new = res[7] ^ c_new;
      end
      OP_ROR: begin
        res   = {c_in, A[7:1]};
        c_new = A[0];
        v_new = res[7] ^ c_new;
      end
      default: res = 8'h00;
    endcase
  end

  // CMP updates flags from the difference but leaves the result register alone.
  always_comb begin
    reg_out_d = (op == OP_CMP) ? reg_out_q : res;
    sreg_d    = {v_new, res[7], (res == 8'h00), c_new};
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_out_q <= 8'h00;
      sreg_q    <= 4'h0;
    end else begin
      reg_out_q <= reg_out_d;
      sreg_q    <= sreg_d;
    end
  end

  assign reg_out = reg_out_q;
  assign SREG    = sreg_q;

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for the registered ALU; expected values are hand-computed.
// SREG is shown as {V,N,Z,C}.
module tb_alu;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] reg_out;
  logic [3:0] SREG;
  logic [3:0] function_select_lines;
  logic [7:0] A;
  logic [7:0] B;

  int tests_run = 0;
  int failed    = 0;

  alu dut (
    .clk                   (clk),
    .rst                   (rst),
    .reg_out               (reg_out),
    .SREG                  (SREG),
    .function_select_lines (function_select_lines),
    .A                     (A),
    .B                     (B)
  );

  always #5 clk = ~clk;

  // Apply one operation, let it be clocked in, then sample 1 time unit after the edge.
  task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    function_select_lines = op;
    A = a;
    B = b;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    issue(4'd1, 8'h55, 8'h22);
    tests_run++;
    if (reg_out !== 8'h00) begin
      failed++; $display("FAIL reset_reg_out: got %h expected 00", reg_out);
    end
    tests_run++;
    if (SREG !== 4'h0) begin
      failed++; $display("FAIL reset_sreg: got %h expected 0", SREG);
    end
    rst = 1'b0;
  endtask

  task automatic test_add_mov;
    issue(4'd1, 8'd6, 8'd9);
    tests_run++;
    if (reg_out !== 8'd15 || SREG !== 4'h0) begin
      failed++; $display("FAIL add_6_9: got %h/%h expected 0f/0", reg_out, SREG);
    end
    issue(4'd0, 8'd1, 8'd2);
    tests_run++;
    if (reg_out !== 8'd2 || SREG !== 4'h0) begin
      failed++; $display("FAIL mov_2: got %h/%h expected 02/0", reg_out, SREG);
    end
  endtask

  task automatic test_sub_borrow;
    issue(4'd2, 8'd3, 8'd6);
    tests_run++;
    if (reg_out !== 8'hFD || SREG !== 4'h5) begin
      failed++; $display("FAIL sub_3_6: got %h/%h expected fd/5", reg_out, SREG);
    end
    issue(4'd2, 8'd3, 8'd50);
    tests_run++;
    if (reg_out !== 8'hD1 || SREG !== 4'h5) begin
      failed++; $display("FAIL sub_3_50: got %h/%h expected d1/5", reg_out, SREG);
    end
  endtask

  task automatic test_overflow;
    issue(4'd1, 8'd127, 8'd125);
    tests_run++;
    if (reg_out !== 8'hFC || SREG !== 4'hC) begin
      failed++; $display("FAIL add_ovf: got %h/%h expected fc/c", reg_out, SREG);
    end
    issue(4'd2, 8'd127, 8'd125);
    tests_run++;
    if (reg_out !== 8'h02 || SREG !== 4'h0) begin
      failed++; $display("FAIL sub_127_125: got %h/%h expected 02/0", reg_out, SREG);
    end
    issue(4'd2, 8'd127, 8'h88);
    tests_run++;
    if (reg_out !== 8'hF7 || SREG !== 4'hD) begin
      failed++; $display("FAIL sub_ovf: got %h/%h expected f7/d", reg_out, SREG);
    end
  endtask

  task automatic test_logic;
    issue(4'd2, 8'h00, 8'h01);  // 0 - 1 leaves C=1 so preservation is visible
    tests_run++;
    if (reg_out !== 8'hFF || SREG !== 4'h5) begin
      failed++; $display("FAIL sub_0_1: got %h/%h expected ff/5", reg_out, SREG);
    end
    issue(4'd3, 8'd1, 8'd2);
    tests_run++;
    if (reg_out !== 8'h00 || SREG !== 4'h3) begin
      failed++; $display("FAIL and_zero: got %h/%h expected 00/3", reg_out, SREG);
    end
    issue(4'd6, 8'd13, 8'd85);
    tests_run++;
    if (reg_out !== 8'h5D || SREG !== 4'h1) begin
      failed++; $display("FAIL or: got %h/%h expected 5d/1", reg_out, SREG);
    end
    issue(4'd7, 8'd13, 8'd85);
    tests_run++;
    if (reg_out !== 8'h58 || SREG !== 4'h1) begin
      failed++; $display("FAIL xor: got %h/%h expected 58/1", reg_out, SREG);
    end
    issue(4'd8, 8'h0F, 8'h00);
    tests_run++;
    if (reg_out !== 8'hF0 || SREG !== 4'h5) begin
      failed++; $display("FAIL not: got %h/%h expected f0/5", reg_out, SREG);
    end
  endtask

  task automatic test_carry_chain;
    issue(4'd1, 8'hFF, 8'h01);
    tests_run++;
    if (reg_out !== 8'h00 || SREG !== 4'h3) begin
      failed++; $display("FAIL add_carry: got %h/%h expected 00/3", reg_out, SREG);
    end
    issue(4'd4, 8'h00, 8'h00);
    tests_run++;
    if (reg_out !== 8'h01 || SREG !== 4'h0) begin
      failed++; $display("FAIL adc_cin: got %h/%h expected 01/0", reg_out, SREG);
    end
    issue(4'd13, 8'h80, 8'h00);
    tests_run++;
    if (reg_out !== 8'h00 || SREG !== 4'hB) begin
      failed++; $display("FAIL rol: got %h/%h expected 00/b", reg_out, SREG);
    end
    issue(4'd14, 8'h00, 8'h00);
    tests_run++;
    if (reg_out !== 8'h80 || SREG !== 4'hC) begin
      failed++; $display("FAIL ror: got %h/%h expected 80/c", reg_out, SREG);
    end
  endtask

  task automatic test_shifts;
    issue(4'd10, 8'h81, 8'h00);
    tests_run++;
    if (reg_out !== 8'h02 || SREG !== 4'h9) begin
      failed++; $display("FAIL lsl: got %h/%h expected 02/9", reg_out, SREG);
    end
    issue(4'd11, 8'h01, 8'h00);
    tests_run++;
    if (reg_out !== 8'h00 || SREG !== 4'hB) begin
      failed++; $display("FAIL lsr: got %h/%h expected 00/b", reg_out, SREG);
    end
    issue(4'd12, 8'h81, 8'h00);
    tests_run++;
    if (reg_out !== 8'hC0 || SREG !== 4'h5) begin
      failed++; $display("FAIL asr: got %h/%h expected c0/5", reg_out, SREG);
    end
  endtask

  task automatic test_neg_sbc;
    issue(4'd9, 8'h01, 8'h00);
    tests_run++;
    if (reg_out !== 8'hFF || SREG !== 4'h5) begin
      failed++; $display("FAIL neg_1: got %h/%h expected ff/5", reg_out, SREG);
    end
    issue(4'd9, 8'h80, 8'h00);
    tests_run++;
    if (reg_out !== 8'h80 || SREG !== 4'hD) begin
      failed++; $display("FAIL neg_80: got %h/%h expected 80/d", reg_out, SREG);
    end
    issue(4'd5, 8'd5, 8'd2);  // borrow-in 1 from the NEG above
    tests_run++;
    if (reg_out !== 8'h02 || SREG !== 4'h0) begin
      failed++; $display("FAIL sbc: got %h/%h expected 02/0", reg_out, SREG);
    end
    issue(4'd9, 8'h00, 8'h00);
    tests_run++;
    if (reg_out !== 8'h00 || SREG !== 4'h2) begin
      failed++; $display("FAIL neg_0: got %h/%h expected 00/2", reg_out, SREG);
    end
  endtask

  task automatic test_back_to_back;
    issue(4'd1, 8'hFF, 8'h01);
    for (int i = 0; i < 2; i++) begin
      issue(4'd4, 8'hFF, 8'h00);  // FF + 0 + C(=1) wraps and re-sets C each cycle
      tests_run++;
      if (reg_out !== 8'h00 || SREG !== 4'h3) begin
        failed++; $display("FAIL adc_hold_%0d: got %h/%h expected 00/3", i, reg_out, SREG);
      end
    end
    issue(4'd4, 8'h01, 8'h00);
    tests_run++;
    if (reg_out !== 8'h02 || SREG !== 4'h0) begin
      failed++; $display("FAIL adc_chain_end: got %h/%h expected 02/0", reg_out, SREG);
    end
  endtask

  task automatic test_reset_mid;
    issue(4'd1, 8'h10, 8'h20);
    tests_run++;
    if (reg_out !== 8'h30 || SREG !== 4'h0) begin
      failed++; $display("FAIL pre_reset_add: got %h/%h expected 30/0", reg_out, SREG);
    end
    rst = 1'b1;
    issue(4'd1, 8'hFF, 8'h01);
    rst = 1'b0;
    tests_run++;
    if (reg_out !== 8'h00 || SREG !== 4'h0) begin
      failed++; $display("FAIL mid_reset: got %h/%h expected 00/0", reg_out, SREG);
    end
  endtask

  task automatic test_cmp;
    issue(4'd0, 8'h00, 8'd7);
    tests_run++;
    if (reg_out !== 8'd7 || SREG !== 4'h0) begin
      failed++; $display("FAIL mov_7: got %h/%h expected 07/0", reg_out, SREG);
    end
    issue(4'd15, 8'd5, 8'd5);
    tests_run++;
    if (reg_out !== 8'd7 || SREG !== 4'h2) begin
      failed++; $display("FAIL cmp_eq: got %h/%h expected 07/2", reg_out, SREG);
    end
    issue(4'd15, 8'd3, 8'd6);
    tests_run++;
    if (reg_out !== 8'd7 || SREG !== 4'h5) begin
      failed++; $display("FAIL cmp_lt: got %h/%h expected 07/5", reg_out, SREG);
    end
  endtask

  initial begin
    rst = 1'b1;
    function_select_lines = 4'd0;
    A = 8'h00;
    B = 8'h00;
    test_reset();
    test_add_mov();
    test_sub_borrow();
    test_overflow();
    test_logic();
    test_carry_chain();
    test_shifts();
    test_neg_sbc();
    test_back_to_back();
    test_reset_mid();
    test_cmp();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

// File: doc/alu.md
# alu

Registered 8-bit arithmetic/logic unit with a 4-bit operation select and a 4-bit status register (SREG). Each rising clock edge it computes one operation on operands A and B, registers the 8-bit result on `reg_out`, and updates the carry, zero, negative and overflow flags. It is the datapath execution unit. The flag register is kept locally so that carry-chained and rotate operations can read it.

## Interface
- No parameters. Data width is fixed at 8 bits.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `reg_out`  output  8  registered result.
- `SREG`  output  4  registered flags: [0]=C carry/borrow, [1]=Z zero, [2]=N negative (result bit 7), [3]=V two's-complement overflow.
- `function_select_lines`  input  4  operation code.
- `A`  input  8  operand A.
- `B`  input  8  operand B.
- Positional port order: `clk, rst, reg_out, SREG, function_select_lines, A, B`.

## Operation
- Operation codes (R = new result, C_in = current SREG[0]):
  - 0: MOV, R = B.
  - 1: ADD, R = A + B.
  - 2: SUB, R = A − B.
  - 3: AND.
  - 4: ADC, R = A + B + C_in.
  - 5: SBC, R = A − B − C_in.
  - 6: OR.
  - 7: XOR.
  - 8: NOT, R = ~A.
  - 9: NEG, R = 0 − A.
  - 10: LSL A.
  - 11: LSR A.
  - 12: ASR A (bit 7 preserved).
  - 13: ROL A through carry (C_in into bit 0).
  - 14: ROR A through carry (C_in into bit 7).
  - 15: CMP, computes A − B for flags only; `reg_out` holds its previous value.
- Arithmetic is on 9-bit unsigned intermediates. The result is the low 8 bits.
- Flag rules:
  - Z = (R == 0) and N = R[7] for every operation; for CMP these use the internal difference.
  - ADD/ADC:
    - C = bit 8 of the sum.
    - V = (A[7] == B[7]) && (R[7] != A[7]).
  - SUB/SBC/CMP/NEG:
    - C = borrow, i.e. unsigned minuend < subtrahend (plus borrow-in for SBC).
    - V = (minuend[7] != subtrahend[7]) && (R[7] != minuend[7]).
    - For NEG the minuend is 0 and the subtrahend is A.
  - MOV, AND, OR, XOR, NOT: C unchanged, V cleared.
  - Shifts and rotates: C = bit shifted out, V = N XOR C (computed from the new values).
- Operands are signless. Signed interpretation affects only V and N.

## Timing
- Outputs are fully registered, with one cycle of latency. Inputs are sampled at rising edge k, and `reg_out`/`SREG` reflect them from just after edge k.
- There is no combinational path from inputs to outputs.
- Reset:
  - When `rst` is high at a rising edge, `reg_out` = 0x00 and `SREG` = 0x0, and the operation is ignored.
  - Reset has priority over every opcode.
  - Reset mid-stream discards the in-flight operation.
- Before the first reset, output values are undefined. The bench must reset first.
- A new operation may be issued every cycle with no handshake.
- C_in for ADC/SBC/ROL/ROR is the SREG value registered at the previous edge. Back-to-back chained ops therefore see the immediately preceding carry.
- Holding the inputs constant re-executes the operation every cycle. For carry-dependent opcodes the outcome may change each cycle; this is the required behaviour.

## Test plan
- Add and MOV, after reset:
  - A=6, B=9, op 1 → `reg_out`=15, SREG=0x0.
  - A=1, B=2, op 0 → 2, SREG unchanged.
- Subtract with borrow:
  - A=3, B=6, op 2 → 0xFD, C=1, N=1, V=0, Z=0.
  - Then B=50 → 0xD1, C=1, N=1.
- Signed overflow:
  - A=127, B=125, op 1 → 0xFC, N=1, V=1, C=0.
  - Op 2 → 0x02, SREG=0x0.
  - B=0x88 (−120), op 2 → 0xF7, C=1, N=1, V=1.
- Logic:
  - A=1, B=2, op 3 → 0x00, Z=1.
  - A=13, B=85, op 6 → 93 (0x5D).
  - Op 7 → 88 (0x58); C is preserved from the prior operation.
- Carry chain and rotate:
  - A=0xFF, B=0x01, op 1 → 0x00, C=1, Z=1.
  - Next cycle A=0, B=0, op 4 → 0x01, C=0.
  - A=0x80, op 13 with C=0 → 0x00, C=1.
  - Then op 14 with A=0x00 → 0x80, C=0.
- Reset mid-stream and CMP:
  - `rst` asserted during an ADD → next outputs are 0x00/0x0.
  - CMP A=5, B=5 after a MOV of 7 → `reg_out` stays 7, Z=1, C=0.
